// File: rtl/poly_eval_horner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : poly_eval_pkg
// Purpose  : Shared constants and field arithmetic for the Horner evaluator:
//            FSM encoding, field selectors, parameter-set defaults, and the
//            byte / extension-field arithmetic used by every lane.
// Revision : 1.0 - initial release
// ============================================================================
package poly_eval_pkg;

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_STEP = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Base-field selectors
    localparam string FIELD_P251  = "P251";
    localparam string FIELD_GF256 = "GF256";

    // Prime modulus of the P251 base field
    localparam logic [8:0] P251_MOD = 9'd251;

    // Low byte of the GF(2^8) reduction polynomial x^8+x^4+x^3+x+1
    localparam logic [7:0] GF256_RED = 8'h1B;

    // Extension field is base[x]/(x^4 - W): x^4 folds back onto W
    localparam logic [7:0] EXT_W_P251  = 8'd3;
    localparam logic [7:0] EXT_W_GF256 = 8'h02;

    // Per-parameter-set defaults (M before the split factor is applied)
    localparam int M_L1 = 230;
    localparam int M_L3 = 352;
    localparam int M_L5 = 480;
    localparam int T_L1 = 3;
    localparam int T_L3 = 3;
    localparam int T_L5 = 4;

    function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ GF256_RED) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] p251_mul(input logic [7:0] a, input logic [7:0] b);
        return 8'((16'(a) * 16'(b)) % 16'(P251_MOD));
    endfunction

    // Operands are below 251, so a single conditional subtract suffices
    function automatic logic [7:0] p251_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= P251_MOD) s = s - P251_MOD;
        return s[7:0];
    endfunction

    function automatic logic [7:0] byte_mul(input logic is_gf, input logic [7:0] a, input logic [7:0] b);
        return is_gf ? gf256_mul(a, b) : p251_mul(a, b);
    endfunction

    function automatic logic [7:0] byte_add(input logic is_gf, input logic [7:0] a, input logic [7:0] b);
        return is_gf ? (a ^ b) : p251_add(a, b);
    endfunction

    // Degree-3 polynomial product, byte k is the coefficient of x^k
    function automatic logic [31:0] ext_mul(input logic is_gf, input logic [31:0] a, input logic [31:0] b);
        logic [7:0] c [7];
        logic [7:0] w;
        for (int i = 0; i < 7; i++) c[i] = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                c[i+j] = byte_add(is_gf, c[i+j], byte_mul(is_gf, a[8*i +: 8], b[8*j +: 8]));
            end
        end
        w = is_gf ? EXT_W_GF256 : EXT_W_P251;
        // x^4..x^6 map onto W*x^0..W*x^2; no term re-enters the upper half
        for (int i = 6; i >= 4; i--) begin
            c[i-4] = byte_add(is_gf, c[i-4], byte_mul(is_gf, w, c[i]));
        end
        return {c[3], c[2], c[1], c[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/poly_eval_horner_if.sv
`default_nettype none
// ============================================================================
// Module   : poly_eval_horner_if
// Purpose  : Start/result handshake and coefficient-RAM read bus of the
//            Horner polynomial evaluator.
// Revision : 1.0 - initial release
// ============================================================================
interface poly_eval_horner_if #(
    parameter int T  = 4,
    parameter int AW = 9
);
    logic            i_start;
    logic [AW-1:0]   i_len;
    logic [AW-1:0]   i_base;
    logic [32*T-1:0] i_r;
    logic [AW-1:0]   o_q_addr;
    logic            o_q_rd;
    logic [7:0]      i_q;
    logic [32*T-1:0] o_eval;
    logic            o_busy;
    logic            o_done;

    // Evaluator side
    modport slave (
        input  i_start, i_len, i_base, i_r, i_q,
        output o_q_addr, o_q_rd, o_eval, o_busy, o_done
    );

    // Controller / coefficient RAM side
    modport master (
        output i_start, i_len, i_base, i_r, i_q,
        input  o_q_addr, o_q_rd, o_eval, o_busy, o_done
    );
endinterface
`default_nettype wire

// File: rtl/poly_eval_horner_lane.sv
`default_nettype none
// ============================================================================
// Module   : horner_lane
// Purpose  : One 32-bit evaluation lane: latched point r, fixed-latency
//            extension-field multiplier (start/done) and the accumulator
//            updated as acc <- acc*r (+) q on byte 0.
// Revision : 1.0 - initial release
// ============================================================================
module horner_lane
    import poly_eval_pkg::*;
#(
    parameter string FIELD   = "P251",
    parameter int    MUL_LAT = 2
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst,
    input  wire logic        i_load,       // run accepted: latch r, clear acc
    input  wire logic [31:0] i_r,
    input  wire logic        i_mul_start,
    input  wire logic        i_acc_we,     // fold product plus coefficient into acc
    input  wire logic [7:0]  i_q,
    output logic             o_mul_done,
    output logic [31:0]      o_acc
);

    localparam bit IS_GF = (FIELD == FIELD_GF256);

    logic [31:0]        r_q;
    logic [31:0]        acc_q;
    logic [31:0]        pipe_q [MUL_LAT];
    logic [MUL_LAT-1:0] vld_q;
    logic [31:0]        w_prod;

    assign w_prod     = pipe_q[MUL_LAT-1];
    assign o_mul_done = vld_q[MUL_LAT-1];
    assign o_acc      = acc_q;

    // Multiplier: product formed at start, then delayed to a fixed latency
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_q <= '0;
            for (int i = 0; i < MUL_LAT; i++) pipe_q[i] <= '0;
        end else begin
            for (int i = MUL_LAT - 1; i > 0; i--) begin
                vld_q[i]  <= vld_q[i-1];
                pipe_q[i] <= pipe_q[i-1];
            end
            vld_q[0]  <= i_mul_start;
            pipe_q[0] <= ext_mul(IS_GF, acc_q, r_q);
        end
    end

    // Evaluation point and accumulator
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q   <= '0;
            acc_q <= '0;
        end else if (i_load) begin
            r_q   <= i_r;
            acc_q <= '0;
        end else if (i_acc_we) begin
            acc_q <= {w_prod[31:8], byte_add(IS_GF, w_prod[7:0], i_q)};
        end
    end

endmodule
`default_nettype wire

// File: rtl/poly_eval_horner.sv
`default_nettype none
// ============================================================================
// Module   : poly_eval_horner
// Purpose  : Horner-rule evaluation of a base-field polynomial at T
//            extension-field points; FSM, coefficient address counter and
//            coefficient register shared by all lanes.
// Revision : 1.0 - initial release
// ============================================================================
module poly_eval_horner
    import poly_eval_pkg::*;
#(
    parameter string FIELD         = "P251",
    parameter string PARAMETER_SET = "L5",
    parameter int    D_SPLIT       = (PARAMETER_SET == "L1") ? 1 : 2,
    parameter int    M             = ((PARAMETER_SET == "L1") ? M_L1 :
                                      (PARAMETER_SET == "L3") ? M_L3 : M_L5) / D_SPLIT,
    parameter int    T             = (PARAMETER_SET == "L1") ? T_L1 :
                                     (PARAMETER_SET == "L3") ? T_L3 : T_L5,
    parameter int    MUL_LAT       = 2,
    parameter int    AW            = $clog2(M) + 1
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst,
    poly_eval_horner_if.slave bus
);

    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   k_q, k_d;
    logic [AW-1:0]   base_q;
    logic [7:0]      q_q;
    logic            first_q;      // first S_WAIT cycle: read data is on i_q
    logic            done_q;

    logic [AW-1:0]   w_len;
    logic            w_accept;
    logic            w_mul_start;
    logic            w_mul_done;
    logic            w_acc_we;
    logic [7:0]      w_addend;
    logic [T-1:0]    w_lane_done;
    logic [32*T-1:0] w_eval;

    assign w_len       = (bus.i_len > AW'(M)) ? AW'(M) : bus.i_len;
    // done_q marks the completion cycle, during which starts are refused
    assign w_accept    = (state_q == S_IDLE) && !done_q && bus.i_start;
    assign w_mul_start = (state_q == S_STEP);
    // Every lane shares one start and identical latency, so all dones coincide
    assign w_mul_done  = &w_lane_done;
    assign w_acc_we    = (state_q == S_WAIT) && w_mul_done;
    // With a one-cycle multiplier the fold happens before q_q is loaded
    assign w_addend    = first_q ? bus.i_q : q_q;

    assign bus.o_q_rd   = (state_q == S_STEP);
    assign bus.o_q_addr = (state_q == S_STEP) ? (base_q + k_q) : '0;
    assign bus.o_busy   = (state_q != S_IDLE) || done_q;
    assign bus.o_done   = done_q;
    assign bus.o_eval   = w_eval;

    // Next-state and coefficient index, highest coefficient first
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_STEP;
                        k_d     = w_len - AW'(1);
                    end
                end
            end
            S_STEP: state_d = S_WAIT;
            S_WAIT: begin
                if (w_mul_done) begin
                    if (k_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_STEP;
                        k_d     = k_q - AW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM, run parameters, coefficient capture and completion pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            base_q  <= '0;
            q_q     <= '0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (w_accept) base_q <= bus.i_base;
            first_q <= (state_q == S_STEP);
            if (first_q) q_q <= bus.i_q;
            done_q  <= (state_q == S_DONE);
        end
    end

    for (genvar j = 0; j < T; j++) begin : g_lane
        horner_lane #(
            .FIELD   (FIELD),
            .MUL_LAT (MUL_LAT)
        ) u_lane (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_load      (w_accept),
            .i_r         (bus.i_r[32*j +: 32]),
            .i_mul_start (w_mul_start),
            .i_acc_we    (w_acc_we),
            .i_q         (w_addend),
            .o_mul_done  (w_lane_done[j]),
            .o_acc       (w_eval[32*j +: 32])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_poly_eval_horner.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_eval_horner
// Purpose  : Self-checking bench: a P251 and a GF256 evaluator (set L3,
//            T=3, M=176) driven in lockstep against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_poly_eval_horner;

    localparam int T    = 3;
    localparam int M    = 176;
    localparam int AW   = 9;
    localparam int ML   = 2;
    localparam int LAT1 = 1 + ML;
    localparam int LIM  = 2000;
    localparam logic [7:0] W_P = 8'd3;
    localparam logic [7:0] W_G = 8'h02;

    logic            clk;
    logic            rst;
    logic            start;
    logic [AW-1:0]   len;
    logic [AW-1:0]   base;
    logic [32*T-1:0] r;
    logic [7:0]      mem [1 << AW];

    int checks;
    int errors;
    int rd_cnt;

    // model state
    bit              running;
    int              cyc;
    int              m_len;
    logic [AW-1:0]   m_base;
    logic [32*T-1:0] res_p, res_g, hold_p, hold_g;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    poly_eval_horner_if #(.T(T), .AW(AW)) bus_p ();
    poly_eval_horner_if #(.T(T), .AW(AW)) bus_g ();

    assign bus_p.i_start = start;
    assign bus_p.i_len   = len;
    assign bus_p.i_base  = base;
    assign bus_p.i_r     = r;
    assign bus_g.i_start = start;
    assign bus_g.i_len   = len;
    assign bus_g.i_base  = base;
    assign bus_g.i_r     = r;

    poly_eval_horner #(.FIELD("P251"), .PARAMETER_SET("L3"), .MUL_LAT(ML)) dut_p (
        .i_clk (clk), .i_rst (rst), .bus (bus_p.slave));
    poly_eval_horner #(.FIELD("GF256"), .PARAMETER_SET("L3"), .MUL_LAT(ML)) dut_g (
        .i_clk (clk), .i_rst (rst), .bus (bus_g.slave));

    // Coefficient RAM: one-cycle read latency, junk when not strobed
    always @(posedge clk) begin
        bus_p.i_q <= bus_p.o_q_rd ? mem[bus_p.o_q_addr] : 8'($urandom);
        bus_g.i_q <= bus_g.o_q_rd ? mem[bus_g.o_q_addr] : 8'($urandom);
    end

    // ---------------- behavioural field model ----------------
    function automatic logic [7:0] bmul(input bit gf, input logic [7:0] a, input logic [7:0] b);
        int p;
        if (!gf) return 8'((int'(a) * int'(b)) % 251);
        p = 0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (int'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (32'h11B << (i - 8));
        return 8'(p);
    endfunction

    function automatic logic [7:0] badd(input bit gf, input logic [7:0] a, input logic [7:0] b);
        return gf ? (a ^ b) : 8'((int'(a) + int'(b)) % 251);
    endfunction

    function automatic logic [31:0] emul(input bit gf, input logic [31:0] a, input logic [31:0] b);
        logic [7:0] c [7];
        logic [7:0] w;
        w = gf ? W_G : W_P;
        for (int i = 0; i < 7; i++) c[i] = 8'd0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                c[i+j] = badd(gf, c[i+j], bmul(gf, a[8*i +: 8], b[8*j +: 8]));
        for (int d = 6; d >= 4; d--) c[d-4] = badd(gf, c[d-4], bmul(gf, w, c[d]));
        return {c[3], c[2], c[1], c[0]};
    endfunction

    function automatic logic [32*T-1:0] horner(input bit gf, input logic [32*T-1:0] rr,
                                               input int n, input logic [AW-1:0] b);
        logic [32*T-1:0] res;
        logic [31:0]     acc;
        logic [AW-1:0]   a;
        for (int j = 0; j < T; j++) begin
            acc = 32'd0;
            for (int k = n - 1; k >= 0; k--) begin
                a = b + AW'(k);
                acc = emul(gf, acc, rr[32*j +: 32]);
                acc[7:0] = badd(gf, acc[7:0], mem[a]);
            end
            res[32*j +: 32] = acc;
        end
        return res;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare process ----------------
    initial begin : compare
        int            lat;
        bit            e_busy, e_done, e_rd;
        logic [AW-1:0] e_addr;
        running = 1'b0;
        cyc     = 0;
        m_len   = 0;
        m_base  = '0;
        hold_p  = '0;
        hold_g  = '0;
        res_p   = '0;
        res_g   = '0;
        rd_cnt  = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            lat    = 2 + m_len * LAT1;
            e_busy = running && cyc >= 1 && cyc <= lat;
            e_done = running && cyc == lat;
            e_rd   = running && cyc >= 1 && cyc < 1 + m_len * LAT1 && ((cyc - 1) % LAT1) == 0;
            e_addr = e_rd ? (m_base + AW'(m_len - 1 - (cyc - 1) / LAT1)) : '0;
            chk("p.busy", 128'(bus_p.o_busy),   128'(e_busy));
            chk("g.busy", 128'(bus_g.o_busy),   128'(e_busy));
            chk("p.done", 128'(bus_p.o_done),   128'(e_done));
            chk("g.done", 128'(bus_g.o_done),   128'(e_done));
            chk("p.rd",   128'(bus_p.o_q_rd),   128'(e_rd));
            chk("g.rd",   128'(bus_g.o_q_rd),   128'(e_rd));
            chk("p.addr", 128'(bus_p.o_q_addr), 128'(e_addr));
            chk("g.addr", 128'(bus_g.o_q_addr), 128'(e_addr));
            if (e_done) begin
                chk("p.eval", 128'(bus_p.o_eval), 128'(res_p));
                chk("g.eval", 128'(bus_g.o_eval), 128'(res_g));
            end else if (!running) begin
                chk("p.hold", 128'(bus_p.o_eval), 128'(hold_p));
                chk("g.hold", 128'(bus_g.o_eval), 128'(hold_g));
            end else if (cyc == 1) begin
                chk("p.clear", 128'(bus_p.o_eval), 128'(0));
                chk("g.clear", 128'(bus_g.o_eval), 128'(0));
            end
            if (bus_p.o_q_rd) rd_cnt++;
            // advance model to the next cycle
            if (rst) begin
                running = 1'b0;
                hold_p  = '0;
                hold_g  = '0;
            end else begin
                if (running) begin
                    cyc++;
                    if (cyc > lat) begin
                        running = 1'b0;
                        hold_p  = res_p;
                        hold_g  = res_g;
                    end
                end
                if (!e_busy && start) begin
                    running = 1'b1;
                    cyc     = 1;
                    m_len   = (int'(len) > M) ? M : int'(len);
                    m_base  = base;
                    res_p   = horner(1'b0, r, m_len, base);
                    res_g   = horner(1'b1, r, m_len, base);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [32*T-1:0] rand_r();
        logic [32*T-1:0] v;
        for (int i = 0; i < 4 * T; i++) v[8*i +: 8] = 8'($urandom_range(0, 250));
        return v;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom_range(0, 250));
    endtask

    // Pulse start; optionally re-pulse start mid-run (extra) or at o_done
    task automatic run(input int n, input logic [AW-1:0] b, input logic [32*T-1:0] rr,
                       input int extra, input bit poke_done, output int lat);
        @(posedge clk); #1;
        len   = AW'(n);
        base  = b;
        r     = rr;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        len   = AW'($urandom);
        base  = AW'($urandom);
        r     = rand_r();
        lat   = 1;
        while (bus_p.o_done !== 1'b1 && lat < LIM) begin
            @(posedge clk); #1;
            lat++;
            start = (lat == extra);
        end
        if (lat >= LIM) begin
            checks++;
            errors++;
            $display("FAIL timeout: no o_done within %0d cycles", LIM);
        end
        if (poke_done) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    initial begin : main
        int lat;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        len    = '0;
        base   = '0;
        r      = '0;
        fill_mem();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.eval", 128'(bus_p.o_eval), 128'(0));
        chk("rst.busy", 128'(bus_p.o_busy), 128'(0));
        chk("rst.rd",   128'(bus_g.o_q_rd), 128'(0));
        rst = 1'b0;

        // q=[1,1,1], r=1
        mem[20] = 8'd1; mem[21] = 8'd1; mem[22] = 8'd1;
        run(3, 9'd20, {T{32'h1}}, 0, 1'b0, lat);
        chk("t1.lat",  128'(lat),          128'(11));
        chk("t1.p",    128'(bus_p.o_eval), 128'({T{32'h3}}));
        chk("t1.g",    128'(bus_g.o_eval), 128'({T{32'h1}}));

        // r=0 leaves only q_0
        mem[40] = 8'h5A; mem[41] = 8'd7; mem[42] = 8'd9;
        run(3, 9'd40, '0, 0, 1'b0, lat);
        chk("t2.p",    128'(bus_p.o_eval), 128'({T{32'h5A}}));
        chk("t2.g",    128'(bus_g.o_eval), 128'({T{32'h5A}}));

        // q=[250,3]: P251 wraps to 2; start lands right after the previous done
        mem[100] = 8'd250; mem[101] = 8'd3;
        rd_cnt = 0;
        run(2, 9'd100, {T{32'h1}}, 0, 1'b1, lat);
        chk("t3.p",    128'(bus_p.o_eval), 128'({T{32'h2}}));
        chk("t3.g",    128'(bus_g.o_eval), 128'({T{32'hF9}}));
        chk("t3.rds",  128'(rd_cnt),       128'(2));

        // len=0
        rd_cnt = 0;
        run(0, 9'd5, rand_r(), 0, 1'b0, lat);
        chk("t4.lat",  128'(lat),          128'(2));
        chk("t4.eval", 128'(bus_p.o_eval), 128'(0));
        chk("t4.rds",  128'(rd_cnt),       128'(0));

        // len=M+5 clamps; base near the top wraps addresses; stray start mid-run
        fill_mem();
        rd_cnt = 0;
        run(M + 5, 9'd400, rand_r(), 4, 1'b0, lat);
        chk("t5.rds",  128'(rd_cnt),       128'(M));
        chk("t5.lat",  128'(lat),          128'(2 + M * LAT1));

        // reset in the first S_WAIT cycle
        @(posedge clk); #1;
        len = 9'd5; base = 9'd60; r = rand_r(); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6.busy", 128'(bus_p.o_busy), 128'(0));
        chk("t6.rd",   128'(bus_g.o_q_rd), 128'(0));
        chk("t6.done", 128'(bus_p.o_done), 128'(0));
        chk("t6.eval", 128'(bus_g.o_eval), 128'(0));

        // randomized runs
        for (int n = 0; n < 14; n++) begin
            int L;
            fill_mem();
            L = (n % 2 == 1) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, M + 5));
            run(L, AW'($urandom), rand_r(), (n % 3 == 0) ? 2 : 0, (n % 4 == 1), lat);
        end
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
